// File: rtl/i2c_reg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_sequencer_pkg
// Description : Shared FSM encoding, transfer direction codes and the default
//               sensor init table for the I2C register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_reg_sequencer_pkg;

    // Sequencer FSM states; encoding is visible on o_state for debug.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INIT_ISSUE = 4'd1,
        ST_INIT_WAIT  = 4'd2,
        ST_POLL_WAIT  = 4'd3,
        ST_RD_ISSUE   = 4'd4,
        ST_RD_WAIT    = 4'd5,
        ST_PUBLISH    = 4'd6
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Init table capacity; each entry is {reg[7:0], data[7:0]}, entry i at [16i+15:16i].
    localparam int INIT_MAX = 16;
    localparam logic [16*INIT_MAX-1:0] INIT_TABLE_DEFAULT = {
        {13{16'h0000}},
        16'h2D08,           // entry 2: POWER_CTL measure
        16'h310B,           // entry 1: DATA_FORMAT full-res +/-16g
        16'h2D00            // entry 0: POWER_CTL standby
    };

endpackage
`default_nettype wire

// File: rtl/i2c_init_rom.sv
`default_nettype none
// ============================================================================
// Module      : i2c_init_rom
// Description : Combinational lookup of init entry index -> {reg, data}.
//               Indices at or beyond INIT_LEN return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_init_rom
    import i2c_reg_sequencer_pkg::*;
#(
    parameter int                     INIT_LEN   = 3,
    parameter logic [16*INIT_MAX-1:0] INIT_TABLE = INIT_TABLE_DEFAULT
)(
    input  logic [3:0] idx,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data
);

    // Table select, guarded so unused slots never leak onto the bus.
    always_comb begin
        reg_addr = 8'h00;
        wr_data  = 8'h00;
        if ({1'b0, idx} < 5'(INIT_LEN)) begin
            {reg_addr, wr_data} = INIT_TABLE[{idx, 4'b0000} +: 16];
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_sequencer
// Description : Command source for an I2C controller. Writes an init list to
//               the sensor, then periodically burst-reads NUM_RD registers and
//               publishes each complete burst as one packed word.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter logic [6:0]             DEV_ADDR   = 7'h1D,
    parameter int                     INIT_LEN   = 3,
    parameter logic [7:0]             RD_BASE    = 8'h32,
    parameter int                     NUM_RD     = 6,
    parameter int                     POLL_DIV   = 50000,
    parameter int                     TIMEOUT    = 200000,
    parameter logic [16*INIT_MAX-1:0] INIT_TABLE = INIT_TABLE_DEFAULT
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_err_clr,
    output logic                  o_enable,
    output logic [6:0]            o_dev_addr,
    output logic [7:0]            o_reg_addr,
    output logic                  o_rw_reg,
    output logic [7:0]            o_w_data,
    input  logic                  i_ready,
    input  logic                  i_finish,
    input  logic [7:0]            i_rd_data,
    output logic [8*NUM_RD-1:0]   o_data,
    output logic                  o_data_valid,
    output logic                  o_init_done,
    output logic                  o_err,
    output logic [3:0]            o_state
);

    localparam int              PW         = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0]   POLL_LAST  = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [3:0]      INIT_LAST  = (INIT_LEN > 0) ? 4'(INIT_LEN - 1) : 4'd0;
    localparam logic [3:0]      RD_LAST    = 4'(NUM_RD - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   finish_q;
    logic [PW-1:0]          poll_cnt;
    logic [TW-1:0]          to_cnt;
    logic [3:0]             init_idx;
    logic [3:0]             rd_idx;
    logic [8*NUM_RD-1:0]    shadow;
    logic [7:0]             rom_reg;
    logic [7:0]             rom_data;

    logic                   finish_evt;
    logic                   timeout_hit;
    logic                   end_txn;
    logic                   issue_init;
    logic                   issue_rd;
    logic                   init_adv;
    logic                   rd_store;
    logic                   publish;
    logic                   set_init_done;
    logic                   clr_init_done;

    i2c_init_rom #(
        .INIT_LEN   (INIT_LEN),
        .INIT_TABLE (INIT_TABLE)
    ) u_init_rom (
        .idx        (init_idx),
        .reg_addr   (rom_reg),
        .wr_data    (rom_data)
    );

    // Only the rising edge of finish counts, so a stretched strobe is seen once.
    assign finish_evt  = i_finish & ~finish_q;
    assign timeout_hit = o_enable & (to_cnt == TO_LAST) & ~finish_evt;
    assign end_txn     = o_enable & (finish_evt | timeout_hit);

    assign o_dev_addr  = DEV_ADDR;
    assign o_state     = state;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_next    = state;
        issue_init    = 1'b0;
        issue_rd      = 1'b0;
        init_adv      = 1'b0;
        rd_store      = 1'b0;
        publish       = 1'b0;
        set_init_done = 1'b0;
        clr_init_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (INIT_LEN == 0) begin
                        set_init_done = 1'b1;
                        state_next    = ST_POLL_WAIT;
                    end else begin
                        clr_init_done = 1'b1;
                        state_next    = ST_INIT_ISSUE;
                    end
                end
            end
            ST_INIT_ISSUE: begin
                if (!i_start) begin
                    state_next = ST_IDLE;
                end else if (i_ready && !o_enable) begin
                    issue_init = 1'b1;
                    state_next = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                // A timed-out entry is skipped rather than retried.
                if (finish_evt || timeout_hit) begin
                    init_adv = 1'b1;
                    if (init_idx == INIT_LAST) begin
                        set_init_done = 1'b1;
                        state_next    = ST_POLL_WAIT;
                    end else begin
                        state_next    = ST_INIT_ISSUE;
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (!i_start) begin
                    state_next = ST_IDLE;
                end else if (poll_cnt == POLL_LAST) begin
                    state_next = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                // Once a burst has begun it runs to its publish regardless of i_start.
                if (!i_start && rd_idx == 4'd0) begin
                    state_next = ST_IDLE;
                end else if (i_ready && !o_enable) begin
                    issue_rd   = 1'b1;
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (finish_evt) begin
                    rd_store = 1'b1;
                    if (rd_idx == RD_LAST) begin
                        state_next = ST_PUBLISH;
                    end else begin
                        state_next = ST_RD_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_POLL_WAIT;
                end
            end
            ST_PUBLISH: begin
                publish    = 1'b1;
                state_next = ST_POLL_WAIT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command bus, counters, burst shadow and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            finish_q     <= 1'b0;
            poll_cnt     <= '0;
            to_cnt       <= '0;
            init_idx     <= 4'd0;
            rd_idx       <= 4'd0;
            shadow       <= '0;
            o_enable     <= 1'b0;
            o_reg_addr   <= 8'h00;
            o_rw_reg     <= RW_WRITE;
            o_w_data     <= 8'h00;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_init_done  <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            finish_q     <= i_finish;
            o_data_valid <= 1'b0;

            // Poll counter restarts from zero on every POLL_WAIT entry.
            if (state == ST_POLL_WAIT) begin
                poll_cnt <= poll_cnt + 1'b1;
            end else begin
                poll_cnt <= '0;
            end

            if (issue_init || issue_rd) begin
                to_cnt <= '0;
            end else if (o_enable) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (issue_init) begin
                o_enable   <= 1'b1;
                o_reg_addr <= rom_reg;
                o_rw_reg   <= RW_WRITE;
                o_w_data   <= rom_data;
            end else if (issue_rd) begin
                o_enable   <= 1'b1;
                o_reg_addr <= RD_BASE + {4'h0, rd_idx};
                o_rw_reg   <= RW_READ;
                o_w_data   <= 8'h00;
            end else if (end_txn) begin
                o_enable   <= 1'b0;
            end

            if (state == ST_IDLE) begin
                init_idx <= 4'd0;
            end else if (init_adv) begin
                init_idx <= init_idx + 4'd1;
            end

            if (state == ST_POLL_WAIT) begin
                rd_idx <= 4'd0;
            end else if (rd_store) begin
                rd_idx <= rd_idx + 4'd1;
                shadow[{rd_idx, 3'b000} +: 8] <= i_rd_data;
            end

            if (publish) begin
                o_data       <= shadow;
                o_data_valid <= 1'b1;
            end

            if (set_init_done) begin
                o_init_done <= 1'b1;
            end else if (clr_init_done) begin
                o_init_done <= 1'b0;
            end

            if (timeout_hit) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_reg_sequencer
// Description : Scoreboard bench for i2c_reg_sequencer with a behavioural
//               I2C controller model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    localparam int NUM_RD   = 6;
    localparam int POLL_DIV = 200;
    localparam int TIMEOUT  = 100;
    localparam logic [47:0] BURST_WORD = 48'hA7A6A5A4A3A2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        err_clr;
    logic        ready;
    logic        finish;
    logic [7:0]  rd_data;
    logic        enable;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_addr;
    logic        rw_reg;
    logic [7:0]  w_data;
    logic [47:0] data;
    logic        data_valid;
    logic        init_done;
    logic        err;
    logic [3:0]  state;

    i2c_reg_sequencer #(
        .NUM_RD   (NUM_RD),
        .POLL_DIV (POLL_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_err_clr    (err_clr),
        .o_enable     (enable),
        .o_dev_addr   (dev_addr),
        .o_reg_addr   (reg_addr),
        .o_rw_reg     (rw_reg),
        .o_w_data     (w_data),
        .i_ready      (ready),
        .i_finish     (finish),
        .i_rd_data    (rd_data),
        .o_data       (data),
        .o_data_valid (data_valid),
        .o_init_done  (init_done),
        .o_err        (err),
        .o_state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Expected command {reg, rw, wdata} and expected published words.
    logic [16:0] exp_cmd[$];
    logic [47:0] exp_data[$];

    int cmd_count   = 0;
    int pubs        = 0;
    int last_en_len = 0;

    // Controller model knobs.
    bit withhold_armed = 0;
    int stretch_len    = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bounded wait: 0 pubs>=n, 1 cmds>=n, 2 state==n, 3 err==1, 4 init_done==1.
    function automatic bit cond_met(input int kind, input int n);
        case (kind)
            0: return pubs >= n;
            1: return cmd_count >= n;
            2: return state == 4'(n);
            3: return err == 1'b1;
            default: return init_done == 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int kind, input int n, input string name);
        int t;
        t = 0;
        while (!cond_met(kind, n) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!cond_met(kind, n)) begin
            errors++;
            $display("FAIL %s wait expired actual=not_reached required=reached", name);
        end
    endtask

    task automatic push_init();
        exp_cmd.push_back({8'h2D, 1'b0, 8'h00});
        exp_cmd.push_back({8'h31, 1'b0, 8'h0B});
        exp_cmd.push_back({8'h2D, 1'b0, 8'h08});
    endtask

    task automatic push_reads(input int n);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = 8'h32 + 8'(k);
            exp_cmd.push_back({a, 1'b1, 8'h00});
        end
    endtask

    // Behavioural controller: busy 40 cycles per command, then a finish strobe.
    initial begin
        int  mcyc;
        int  fin_left;
        bit  busy;
        bit  withheld;
        ready    = 1'b1;
        finish   = 1'b0;
        rd_data  = 8'h00;
        mcyc     = 0;
        fin_left = 0;
        busy     = 0;
        withheld = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; ready = 1'b1; finish = 1'b0; fin_left = 0;
            end else if (fin_left > 0) begin
                fin_left--;
                if (fin_left == 0) begin
                    finish = 1'b0; ready = 1'b1; busy = 0;
                end
            end else if (busy) begin
                if (!enable) begin
                    busy = 0; ready = 1'b1;
                end else begin
                    mcyc++;
                    if (mcyc == 40 && !withheld) begin
                        finish   = 1'b1;
                        rd_data  = 8'hA0 + {4'h0, reg_addr[3:0]};
                        fin_left = stretch_len;
                        if (stretch_len > 1) ready = 1'b1;
                    end
                end
            end else if (enable) begin
                busy = 1; mcyc = 0; ready = 1'b0;
                withheld = withhold_armed && rw_reg && reg_addr == 8'h34;
                if (withheld) withhold_armed = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each command issue and each publish.
    initial begin
        int          cyc;
        int          poll_t;
        int          en_len;
        bit          unstable;
        logic        prev_en;
        logic        prev_valid;
        logic [3:0]  prev_state;
        logic [16:0] cap;
        logic [16:0] e;
        logic [47:0] d;
        cyc = 0; poll_t = 0; en_len = 0; unstable = 0;
        prev_en = 1'b0; prev_valid = 1'b0; prev_state = 4'd0; cap = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (enable === 1'b1 && prev_en === 1'b0) begin
                cmd_count++;
                cap = {reg_addr, rw_reg, w_data};
                unstable = 0;
                en_len = 1;
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected actual=%0h required=none", cap);
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd", {dev_addr, cap}, {7'h1D, e});
                end
            end else if (enable === 1'b1) begin
                en_len++;
                if ({reg_addr, rw_reg, w_data} !== cap) unstable = 1;
            end else if (prev_en === 1'b1) begin
                last_en_len = en_len;
                check("cmd_stable", 64'(unstable), 64'd0);
            end
            if (prev_valid === 1'b1) begin
                check("valid_pulse", 64'(data_valid), 64'd0);
            end
            if (data_valid === 1'b1) begin
                pubs++;
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL publish_unexpected actual=%0h required=none", data);
                end else begin
                    d = exp_data.pop_front();
                    check("publish_data", 64'(data), 64'(d));
                end
            end
            if (state == 4'd3 && prev_state != 4'd3) poll_t = cyc;
            if (state == 4'd4 && prev_state == 4'd3) begin
                check("poll_period", 64'(cyc - poll_t), 64'(POLL_DIV));
            end
            prev_en    = enable;
            prev_valid = data_valid;
            prev_state = state;
        end
    end

    // Directed scenario sequence.
    initial begin
        int base;
        int c;
        rst = 1'b1; start = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable",    64'(enable),     64'd0);
        check("rst_reg_addr",  64'(reg_addr),   64'd0);
        check("rst_rw",        64'(rw_reg),     64'd0);
        check("rst_w_data",    64'(w_data),     64'd0);
        check("rst_data",      64'(data),       64'd0);
        check("rst_valid",     64'(data_valid), 64'd0);
        check("rst_init_done", 64'(init_done),  64'd0);
        check("rst_err",       64'(err),        64'd0);
        check("rst_state",     64'(state),      64'd0);
        rst = 1'b0;

        // Init list.
        push_init();
        start = 1'b1;
        wait_for(1, 3, "init_third_issue");
        check("init_done_early", 64'(init_done), 64'd0);
        wait_for(4, 0, "init_done");
        check("init_cmd_count", 64'(cmd_count), 64'd3);
        check("init_queue", 64'(exp_cmd.size()), 64'd0);

        // Normal burst.
        push_reads(NUM_RD);
        exp_data.push_back(BURST_WORD);
        wait_for(0, 1, "burst1");
        @(negedge clk);
        check("burst1_word", 64'(data), 64'(BURST_WORD));

        // Timeout on the third read of the next burst.
        withhold_armed = 1;
        push_reads(3);
        wait_for(3, 0, "timeout_err");
        @(negedge clk);
        check("timeout_len", 64'(last_en_len), 64'(TIMEOUT));
        check("timeout_enable", 64'(enable), 64'd0);
        check("timeout_data_held", 64'(data), 64'(BURST_WORD));
        check("timeout_no_publish", 64'(pubs), 64'd1);
        check("timeout_queue", 64'(exp_cmd.size()), 64'd0);

        // Recovery burst, then clear the sticky error.
        push_reads(NUM_RD);
        exp_data.push_back(BURST_WORD);
        wait_for(0, 2, "burst_after_timeout");
        check("err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 64'(err), 64'd0);

        // Stop requested mid-burst: burst completes, then idle.
        base = cmd_count;
        push_reads(NUM_RD);
        exp_data.push_back(BURST_WORD);
        wait_for(1, base + 3, "stop_k2_issue");
        start = 1'b0;
        wait_for(0, 3, "stop_publish");
        wait_for(2, 0, "stop_idle");
        c = cmd_count;
        repeat (400) @(negedge clk);
        check("stop_no_cmd", 64'(cmd_count), 64'(c));
        check("stop_state", 64'(state), 64'd0);
        check("stop_init_kept", 64'(init_done), 64'd1);
        check("stop_queue", 64'(exp_cmd.size()), 64'd0);

        // Restart re-runs init, then a burst with stretched finish strobes.
        push_init();
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("restart_init_clr", 64'(init_done), 64'd0);
        wait_for(4, 0, "restart_init_done");
        stretch_len = 5;
        push_reads(NUM_RD);
        exp_data.push_back(BURST_WORD);
        wait_for(0, 4, "stretch_burst");
        stretch_len = 1;
        check("stretch_queue", 64'(exp_cmd.size()), 64'd0);

        // Reset in the middle of a read transaction.
        base = cmd_count;
        push_reads(NUM_RD);
        wait_for(1, base + 2, "mid_burst_issue");
        wait_for(2, 5, "mid_rd_wait");
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("mrst_enable",    64'(enable),     64'd0);
        check("mrst_reg_addr",  64'(reg_addr),   64'd0);
        check("mrst_rw",        64'(rw_reg),     64'd0);
        check("mrst_data",      64'(data),       64'd0);
        check("mrst_init_done", 64'(init_done),  64'd0);
        check("mrst_state",     64'(state),      64'd0);
        rst = 1'b0;
        exp_cmd.delete();
        c = cmd_count;
        repeat (100) @(negedge clk);
        check("mrst_quiet", 64'(cmd_count), 64'(c));
        check("data_queue", 64'(exp_data.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
